// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR filter. One signed MAC walks a circular sample
// buffer over TAPS cycles per accepted sample; coefficients are loaded at run time.
//
// Optional feature macro: FIR_RND_SAT_EN
//   undefined: yout = (acc >>> SHIFT) truncated to DOUT_W bits (floor, wrap on overflow)
//   defined:   round half up before the shift, then saturate to the DOUT_W range
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   en, xin    input sample strobe and signed sample
//   rdy        block can accept a sample (and a coefficient write) this cycle
//   drop       one-cycle pulse: en was high while rdy was low
//   coef_we    coefficient write strobe, with coef_addr (tap index) and coef_din
//   valid      one-cycle pulse: yout holds a new result
//   yout       signed filter output, held between valid pulses
module fir_serial_mac #(
  parameter int unsigned DIN_W  = 12,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned DOUT_W = 29,
  localparam int unsigned IDX_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic signed [DIN_W-1:0]  xin,
  output logic                     rdy,
  output logic                     drop,
  input  logic                     coef_we,
  input  logic [IDX_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_din,
  output logic                     valid,
  output logic signed [DOUT_W-1:0] yout
);

  localparam int unsigned PROD_W = DIN_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + IDX_W;
  // Wide enough for the rounding add and for the output range, plus a guard bit.
  localparam int unsigned EXT_W  = ((ACC_W + 1 > DOUT_W) ? ACC_W + 1 : DOUT_W) + 1;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                    state_q, state_d;
  logic signed [DIN_W-1:0]   samp_q [TAPS];
  logic signed [DIN_W-1:0]   samp_d [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          wp_q, wp_d;
  logic [IDX_W-1:0]          j_q, j_d;
  logic                      valid_q, valid_d;
  logic                      drop_q, drop_d;
  logic signed [DOUT_W-1:0]  yout_q, yout_d;

  logic [IDX_W-1:0]          rd_idx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [DOUT_W-1:0]  yout_scaled;
  logic signed [EXT_W-1:0]   acc_ext, acc_shr;

  // OUT is a ready state too, so a new sample can be taken while the result is registered;
  // this gives the TAPS+1 cycle minimum spacing.
  assign rdy = (state_q == StIdle) || (state_q == StOut);

  // (wp - j) mod TAPS. Modular IDX_W arithmetic keeps the low bits exact when wrapping.
  always_comb begin
    if (wp_q >= j_q) begin
      rd_idx = wp_q - j_q;
    end else begin
      rd_idx = wp_q + IDX_W'(TAPS) - j_q;
    end
    prod = samp_q[rd_idx] * coef_q[j_q];
  end

`ifdef FIR_RND_SAT_EN
  logic signed [EXT_W-1:0] sat_max, sat_min;

  always_comb begin
    sat_max              = '0;
    sat_max[DOUT_W-2:0]  = '1;
    sat_min              = ~sat_max;
    // Adds 2^(SHIFT-1) when SHIFT>0, nothing when SHIFT==0.
    acc_ext = EXT_W'(acc_q) + ((EXT_W'(1) << SHIFT) >>> 1);
    acc_shr = acc_ext >>> SHIFT;
    if (acc_shr > sat_max) begin
      yout_scaled = sat_max[DOUT_W-1:0];
    end else if (acc_shr < sat_min) begin
      yout_scaled = sat_min[DOUT_W-1:0];
    end else begin
      yout_scaled = acc_shr[DOUT_W-1:0];
    end
  end
`else
  logic unused_hi;

  always_comb begin
    acc_ext     = EXT_W'(acc_q);
    acc_shr     = acc_ext >>> SHIFT;
    yout_scaled = acc_shr[DOUT_W-1:0];
  end

  // Bits above DOUT_W are discarded: overflow wraps.
  assign unused_hi = ^acc_shr[EXT_W-1:DOUT_W];
`endif

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    wp_d    = wp_q;
    j_d     = j_q;
    valid_d = 1'b0;
    drop_d  = en && !rdy;
    yout_d  = yout_q;

    // Coefficient write lands before a coincident sample's MAC starts.
    if (coef_we && rdy && (32'(coef_addr) < TAPS)) begin
      coef_d[coef_addr] = coef_din;
    end

    unique case (state_q)
      StIdle: begin
        if (en) begin
          samp_d[wp_q] = xin;
          acc_d        = '0;
          j_d          = '0;
          state_d      = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + {{IDX_W{prod[PROD_W-1]}}, prod};
        if (j_q == IDX_W'(TAPS - 1)) begin
          j_d     = '0;
          wp_d    = (wp_q == IDX_W'(TAPS - 1)) ? '0 : wp_q + 1'b1;
          state_d = StOut;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StOut: begin
        valid_d = 1'b1;
        yout_d  = yout_scaled;
        state_d = StIdle;
        if (en) begin
          samp_d[wp_q] = xin;
          acc_d        = '0;
          j_d          = '0;
          state_d      = StMac;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(TAPS); i++) begin
        samp_q[i] <= '0;
        coef_q[i] <= '0;
      end
      acc_q   <= '0;
      wp_q    <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      yout_q  <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      wp_q    <= wp_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      yout_q  <= yout_d;
    end
  end

  assign valid = valid_q;
  assign drop  = drop_q;
  assign yout  = yout_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: three instances (defaults, DOUT_W=16 saturation,
// SHIFT=4 rounding). Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_fir_serial_mac;

  logic clk;
  logic rstn;
  logic               en_a      [3];
  logic signed [11:0] xin_a     [3];
  logic               coef_we_a [3];
  logic [3:0]         coef_addr_a [3];
  logic signed [11:0] coef_din_a  [3];

  logic rdy0, drop0, valid0;
  logic rdy1, drop1, valid1;
  logic rdy2, drop2, valid2;
  logic signed [28:0] yout0;
  logic signed [15:0] yout1;
  logic signed [28:0] yout2;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int drop_cnt = 0;

  longint exp_q0[$];
  longint exp_q1[$];
  longint exp_q2[$];
  int     edge_q[$];

  fir_serial_mac u_dut (
    .clk(clk), .rstn(rstn), .en(en_a[0]), .xin(xin_a[0]), .rdy(rdy0), .drop(drop0),
    .coef_we(coef_we_a[0]), .coef_addr(coef_addr_a[0]), .coef_din(coef_din_a[0]),
    .valid(valid0), .yout(yout0)
  );

  fir_serial_mac #(.DOUT_W(16), .SHIFT(0)) u_sat (
    .clk(clk), .rstn(rstn), .en(en_a[1]), .xin(xin_a[1]), .rdy(rdy1), .drop(drop1),
    .coef_we(coef_we_a[1]), .coef_addr(coef_addr_a[1]), .coef_din(coef_din_a[1]),
    .valid(valid1), .yout(yout1)
  );

  fir_serial_mac #(.SHIFT(4)) u_rnd (
    .clk(clk), .rstn(rstn), .en(en_a[2]), .xin(xin_a[2]), .rdy(rdy2), .drop(drop2),
    .coef_we(coef_we_a[2]), .coef_addr(coef_addr_a[2]), .coef_din(coef_din_a[2]),
    .valid(valid2), .yout(yout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output model for a full-precision accumulator value.
  function automatic longint scale(input longint acc, input int sh, input int w);
    longint r;
    longint mx;
`ifdef FIR_RND_SAT_EN
    if (sh > 0) acc = acc + (64'sd1 <<< (sh - 1));
    r  = acc >>> sh;
    mx = (64'sd1 <<< (w - 1)) - 1;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
`else
    r  = acc >>> sh;
    mx = (64'sd1 <<< w) - 1;
    r  = r & mx;
    if (r >= (64'sd1 <<< (w - 1))) r = r - (64'sd1 <<< w);
`endif
    return r;
  endfunction

  // Monitor: every valid must match the oldest expected value.
  longint m_e;
  int     m_a;
  always @(negedge clk) begin
    if (drop0) drop_cnt <= drop_cnt + 1;
    if (valid0) begin
      if (exp_q0.size() == 0) begin
        chk("dut0 unexpected valid", 1, 0);
      end else begin
        m_e = exp_q0.pop_front();
        m_a = edge_q.pop_front();
        chk("dut0 yout", yout0, m_e);
        chk("dut0 latency", cyc - m_a, 17);
      end
    end
    if (valid1) begin
      if (exp_q1.size() == 0) chk("sat unexpected valid", 1, 0);
      else chk("sat yout", yout1, exp_q1.pop_front());
    end
    if (valid2) begin
      if (exp_q2.size() == 0) chk("rnd unexpected valid", 1, 0);
      else chk("rnd yout", yout2, exp_q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int id, input int a, input int v);
    coef_we_a[id]   = 1'b1;
    coef_addr_a[id] = 4'(a);
    coef_din_a[id]  = 12'(v);
    tick();
    coef_we_a[id]   = 1'b0;
  endtask

  // One sample, then idle until the next 17-cycle slot; optional coincident coef write.
  task automatic send(input int id, input int x, input longint e, input bit we,
                      input int ca, input int cv);
    case (id)
      0: begin exp_q0.push_back(e); edge_q.push_back(cyc + 1); end
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
    en_a[id]  = 1'b1;
    xin_a[id] = 12'(x);
    if (we) begin
      coef_we_a[id]   = 1'b1;
      coef_addr_a[id] = 4'(ca);
      coef_din_a[id]  = 12'(cv);
    end
    tick();
    en_a[id]      = 1'b0;
    coef_we_a[id] = 1'b0;
    repeat (16) tick();
  endtask

  int d0;
  int e0;

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b0; xin_a[i] = '0; coef_we_a[i] = 1'b0; coef_addr_a[i] = '0;
      coef_din_a[i] = '0;
    end
    repeat (3) tick();
    rstn = 1'b1;
    #4;
    chk("reset rdy", rdy0, 1);
    chk("reset valid", valid0, 0);
    chk("reset drop", drop0, 0);
    chk("reset yout", yout0, 0);
    chk("reset sat rdy", rdy1, 1);
    tick();

    // Impulse through coef[j]=j+1.
    for (int j = 0; j < 16; j++) wr_coef(0, j, j + 1);
    for (int n = 0; n < 17; n++) send(0, (n == 0) ? 1 : 0, (n < 16) ? n + 1 : 0, 0, 0, 0);

    // DC ramp and hold over three wp wraps.
    for (int j = 0; j < 16; j++) wr_coef(0, j, 1);
    for (int n = 0; n < 48; n++) send(0, 100, (n < 16) ? 100 * (n + 1) : 1600, 0, 0, 0);
    chk("dc yout held", yout0, 1600);

    // Overrun: en high 40 cycles, xin = cycle index + 1; accepts 1, 18, 35.
    e0 = cyc + 1;
    d0 = drop_cnt;
    exp_q0.push_back(1501); edge_q.push_back(e0);
    exp_q0.push_back(1419); edge_q.push_back(e0 + 17);
    exp_q0.push_back(1354); edge_q.push_back(e0 + 34);
    en_a[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      xin_a[0] = 12'(i + 1);
      tick();
    end
    en_a[0] = 1'b0;
    repeat (20) tick();
    chk("overrun drop count", drop_cnt - d0, 37);

    // Coefficient write during MAC is ignored.
    exp_q0.push_back(1261); edge_q.push_back(cyc + 1);
    en_a[0] = 1'b1; xin_a[0] = 12'sd7;
    tick();
    en_a[0] = 1'b0;
    repeat (2) tick();
    chk("rdy low in mac", rdy0, 0);
    wr_coef(0, 0, 5);
    repeat (13) tick();
    // Same write coincident with en in IDLE takes effect for that sample.
    send(0, 3, 1176, 1, 0, 5);
    repeat (3) tick();

    // Reset mid-MAC: no valid, state cleared.
    en_a[0] = 1'b1; xin_a[0] = 12'sd9;
    tick();
    en_a[0] = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #4;
    chk("post-reset rdy", rdy0, 1);
    chk("post-reset yout", yout0, 0);
    chk("post-reset valid", valid0, 0);
    repeat (25) tick();
    send(0, 1, 0, 0, 0, 0);                 // coefficients cleared
    for (int j = 0; j < 16; j++) wr_coef(0, j, 1);
    send(0, 0, 1, 0, 0, 0);                 // only the just-written 1 remains in the buffer

    // Saturation instance: all coef 2047, xin 2047 for 16 samples.
    for (int j = 0; j < 16; j++) wr_coef(1, j, 2047);
    for (int n = 1; n <= 16; n++) send(1, 2047, scale(longint'(n) * 4190209, 0, 16), 0, 0, 0);
    repeat (2) tick();
`ifdef FIR_RND_SAT_EN
    chk("sat full acc", yout1, 32767);
`else
    chk("sat full acc", yout1, 16);
`endif

    // Rounding instance: acc = 24 then -24 with SHIFT=4.
    wr_coef(2, 0, 3);
`ifdef FIR_RND_SAT_EN
    send(2, 8, 2, 0, 0, 0);
    send(2, -8, -1, 0, 0, 0);
`else
    send(2, 8, 1, 0, 0, 0);
    send(2, -8, -2, 0, 0, 0);
`endif

    repeat (5) tick();
    chk("dut0 pending", exp_q0.size(), 0);
    chk("sat pending", exp_q1.size(), 0);
    chk("rnd pending", exp_q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
